// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter.
// XLEN    : operand/result width of the shared multiplier.
// MUL_LAT : multiplier latency, operand cycle to result cycle.
// IDW     : requester-id width carried in a tag; sized for up to 8 requesters.
// tag_t   : one stage of the in-flight tag pipeline {vld, id}.
package mul_arb_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned IDW     = 3;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   advance  : move the pointer to the granted index when a grant is made
//   gnt      : one-hot grant (combinational)
//   gnt_id   : index of the granted requester
//   any      : a grant is made this cycle
// The search starts just after the last grant and wraps, so after reset
// (pointer = N-1) requester 0 has first priority.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    logic [IW-1:0] last_q;

    always_comb begin
        logic [IW-1:0] idx;
        idx    = '0;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = IW'((32'(last_q) + off) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                any      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else if (advance && any) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_valid_i  : per-requester request valid
//   req_ready_o  : one-hot combinational grant
//   req_op1_i/2_i: packed operands, requester i at [i*XLEN +: XLEN]
//   resp_valid_o : per-requester buffered result valid
//   resp_ready_i : per-requester result consume
//   resp_data_o  : packed buffered results
//   mul_op1_o/2_o: operands to the shared multiplier (0 when idle)
//   mul_result_i : multiplier result, MUL_LAT cycles after the operands
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_op1_i,
    input  logic [NREQ*XLEN-1:0] req_op2_i,
    output logic [NREQ-1:0]      resp_valid_o,
    input  logic [NREQ-1:0]      resp_ready_i,
    output logic [NREQ*XLEN-1:0] resp_data_o,
    output logic [XLEN-1:0]      mul_op1_o,
    output logic [XLEN-1:0]      mul_op2_o,
    input  logic [XLEN-1:0]      mul_result_i
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] busy_q, busy_d;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic            gnt_any;
    tag_t            tag_q [MUL_LAT];
    tag_t            tag_fin;
    logic [XLEN-1:0] buf_q [NREQ];
    logic [NREQ-1:0] rvalid_q;

    // No grants while reset is held so nothing is issued into a pipeline
    // that is being flushed.
    assign eligible = rst ? '0 : (req_valid_i & ~busy_q);

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .advance (1'b1),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any     (gnt_any)
    );

    assign req_ready_o = gnt;

    always_comb begin
        mul_op1_o = '0;
        mul_op2_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mul_op1_o = req_op1_i[i*XLEN +: XLEN];
                mul_op2_o = req_op2_i[i*XLEN +: XLEN];
            end
        end
    end

    // Tag pipeline mirrors the multiplier so the final stage names the owner
    // of the result currently on mul_result_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: gnt_any, id: IDW'(gnt_id)};
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_fin = tag_q[MUL_LAT-1];

    // A capture and a handshake never hit the same requester together: busy
    // keeps a second operation out until the buffered one is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (tag_fin.vld && (tag_fin.id == IDW'(i))) begin
                    buf_q[i]    <= mul_result_i;
                    rvalid_q[i] <= 1'b1;
                end else if (rvalid_q[i] && resp_ready_i[i]) begin
                    rvalid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy_d = (busy_q | gnt) & ~(rvalid_q & resp_ready_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign resp_valid_o = rvalid_q;

    always_comb begin
        resp_data_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_data_o[i*XLEN +: XLEN] = buf_q[i];
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*64-1:0] req_op1, req_op2, resp_data;
    logic [63:0]    mul_op1, mul_op2, mul_result;

    always #5 clk = ~clk;

    mul_arbiter #(
        .NREQ (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op1_i    (req_op1),
        .req_op2_i    (req_op2),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .mul_op1_o    (mul_op1),
        .mul_op2_o    (mul_op2),
        .mul_result_i (mul_result)
    );

    // Environment model of the shared multiplier: fixed latency, no reset.
    logic [63:0] mp [MUL_LAT];
    always_ff @(posedge clk) begin
        mp[0] <= $signed(mul_op1) * $signed(mul_op2);
        for (int s = 1; s < MUL_LAT; s++) mp[s] <= mp[s-1];
    end
    assign mul_result = mp[MUL_LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: per-requester outstanding flag, issue cycle and
    // expected product; round-robin pointer over eligible requesters.
    logic [N-1:0] m_busy;
    int           m_issue [N];
    logic [63:0]  m_prod  [N];
    int           m_last;
    int           cyc;

    logic [N-1:0]    s_ready, s_rvalid;
    logic [N*64-1:0] s_rdata;
    logic [63:0]     s_op1, s_op2;

    task automatic cycle();
        int eg;
        logic [N-1:0] er;
        logic [63:0] e1, e2;
        logic ev;
        logic signed [63:0] a, b;
        @(negedge clk);
        s_ready  = req_ready;
        s_rvalid = resp_valid;
        s_rdata  = resp_data;
        s_op1    = mul_op1;
        s_op2    = mul_op2;
        eg = -1;
        if (!rst) begin
            for (int off = 1; off <= N; off++) begin
                int idx;
                idx = (m_last + off) % N;
                if (eg < 0 && req_valid[idx] && !m_busy[idx]) eg = idx;
            end
        end
        er = '0;
        e1 = '0;
        e2 = '0;
        if (eg >= 0) begin
            er[eg] = 1'b1;
            e1 = req_op1[eg*64 +: 64];
            e2 = req_op2[eg*64 +: 64];
        end
        chk("grant", 64'(s_ready), 64'(er));
        chk("mul_op1", s_op1, e1);
        chk("mul_op2", s_op2, e2);
        for (int i = 0; i < N; i++) begin
            ev = m_busy[i] && (cyc >= m_issue[i] + MUL_LAT + 1);
            chk($sformatf("resp_valid[%0d]", i), 64'(s_rvalid[i]), 64'(ev));
            if (ev) chk($sformatf("resp_data[%0d]", i), s_rdata[i*64 +: 64], m_prod[i]);
            if (!rst && ev && resp_ready[i]) m_busy[i] = 1'b0;
        end
        if (rst) begin
            m_busy = '0;
            m_last = N - 1;
        end else if (eg >= 0) begin
            a = e1;
            b = e2;
            m_busy[eg]  = 1'b1;
            m_issue[eg] = cyc;
            m_prod[eg]  = a * b;
            m_last      = eg;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd();
        case ($urandom_range(0, 7))
            0:       return 64'h8000_0000_0000_0000;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        int          r;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic issue_one(vec_t v, string name);
        int lat;
        logic [N-1:0] one;
        one = '0;
        one[v.r] = 1'b1;
        req_valid = one;
        req_op1[v.r*64 +: 64] = v.a;
        req_op2[v.r*64 +: 64] = v.b;
        cycle();
        chk({name, " grant"}, 64'(s_ready), 64'(one));
        req_valid = '0;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!s_rvalid[v.r] && lat < 12);
        chk({name, " latency"}, 64'(lat), 64'(MUL_LAT + 1));
        chk({name, " data"}, s_rdata[v.r*64 +: 64], v.exp);
    endtask

    vec_t vecs [7];

    initial begin
        int prev, g, grants, k, granted;
        int cnt [N];
        logic [63:0] held;
        logic        have_held;

        rst        = 1'b1;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        resp_ready = '1;
        m_busy     = '0;
        m_last     = N - 1;
        cyc        = 0;
        for (int i = 0; i < N; i++) begin
            m_issue[i] = 0;
            m_prod[i]  = '0;
        end
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("reset ready", 64'(s_ready), 64'h0);
        chk("reset resp_valid", 64'(s_rvalid), 64'h0);
        for (int i = 0; i < N; i++) chk($sformatf("reset data[%0d]", i), s_rdata[i*64 +: 64], 64'h0);
        chk("reset mul_op1", s_op1, 64'h0);

        vecs[0] = '{0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000};
        vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[4] = '{0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
        vecs[5] = '{1, 64'd123456789, 64'd1000, 64'h0000_001C_BE99_1A08};
        vecs[6] = '{2, 64'hFFFF_FFFF_FFFF_FFFB, 64'd6, 64'hFFFF_FFFF_FFFF_FFE2};
        for (int i = 0; i < 7; i++) issue_one(vecs[i], $sformatf("vec%0d", i));

        // Fairness: every requester always valid, results consumed at once.
        for (int i = 0; i < N; i++) begin
            req_op1[i*64 +: 64] = rnd();
            req_op2[i*64 +: 64] = rnd();
        end
        req_valid = '1;
        prev = -1;
        grants = 0;
        repeat (40) begin
            cycle();
            if (s_ready != 0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (s_ready[i]) g = i;
                if (prev >= 0) chk("rr_order", 64'(g), 64'((prev + 1) % N));
                prev = g;
                grants++;
            end
        end
        chk("fair_grant_count", 64'(grants >= 24), 64'h1);
        req_valid = '0;
        repeat (8) cycle();

        // Backpressure on requester 2 while everyone keeps requesting.
        resp_ready = 4'b1011;
        req_valid  = '1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        have_held = 1'b0;
        held = '0;
        repeat (20) begin
            cycle();
            for (int i = 0; i < N; i++) if (s_ready[i]) cnt[i]++;
            if (s_rvalid[2]) begin
                if (have_held) chk("bp_hold", s_rdata[2*64 +: 64], held);
                held = s_rdata[2*64 +: 64];
                have_held = 1'b1;
            end
        end
        chk("bp_one_grant", 64'(cnt[2]), 64'd1);
        chk("bp_valid_held", 64'(s_rvalid[2]), 64'h1);
        chk("bp_others", 64'(cnt[0] >= 2 && cnt[1] >= 2 && cnt[3] >= 2), 64'h1);
        req_valid  = '0;
        resp_ready = '1;
        repeat (10) cycle();

        // Reset one cycle after a grant discards the operation.
        req_valid = 4'b0010;
        cycle();
        chk("rst_mid grant", 64'(s_ready), 64'h2);
        req_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("rst_mid no resp", 64'(s_rvalid), 64'h0);
        end
        req_valid = 4'b0010;
        cycle();
        chk("rst_mid regrant", 64'(s_ready), 64'h2);
        req_valid = '0;
        repeat (8) cycle();

        // Random soak.
        granted = 0;
        k = 0;
        while (granted < 2000 && k < 30000) begin
            req_valid  = N'($urandom);
            resp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_op1[i*64 +: 64] = rnd();
                req_op2[i*64 +: 64] = rnd();
            end
            cycle();
            if (s_ready != 0) granted++;
            k++;
        end
        chk("soak_completed", 64'(granted >= 2000), 64'h1);
        req_valid  = '0;
        resp_ready = '1;
        repeat (10) cycle();
        chk("soak_drained", 64'(s_rvalid), 64'h0);
        chk("soak_no_pending", 64'(m_busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
